c2f_req_tracker: RTL and testbench



---
 rtl/lotr_pkg.sv | 30 +++
 rtl/c2f_thread_slot.sv | 94 +++++++++
 rtl/c2f_req_tracker.sv | 174 +++++++++++++++++
 tb/tb_c2f_req_tracker.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lotr_pkg.sv
// Shared types and constants for the core-to-fabric request tracker.
package lotr_pkg;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } t_opcode;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } t_slotState;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
    localparam int          MAX_THREADS  = 8;

    // Binary index of the set bit in a one-hot thread vector (zero when none is set).
    function automatic logic [2:0] encodeOneHot8(input logic [7:0] oneHot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_THREADS; i++) begin
            if (oneHot[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/c2f_thread_slot.sv
// Per-thread read tracker: waits for the ring response, buffers it and hands
// it back when the thread is scheduled again. A watchdog fills in poison data
// if the response never shows up.

`ifndef LOTR_RST_MSFF
`define LOTR_RST_MSFF(q, d, clk, rst, rstVal) \
    always_ff @(posedge clk) begin \
        if (rst) q <= rstVal; \
        else     q <= d; \
    end
`endif

module c2f_thread_slot
    import lotr_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        QClk,
    input  logic        RstQnnnH,
    input  logic        rdAccept,
    input  logic        rspHit,
    input  logic [31:0] rspData,
    input  logic        threadSel,
    output logic        rcAccess,
    output logic        matchFire,
    output logic [31:0] bufData,
    output logic        timeoutErr
);

    localparam int              CNT_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

    t_slotState       state;
    t_slotState       stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic [31:0]      bufNext;
    logic             timeoutErrNext;
    logic             timeoutHit;

    assign timeoutHit = TIMEOUT_EN && (cnt == CNT_LAST);
    assign rcAccess   = (state != IDLE);

    // Next-state logic: the counter only runs in WAIT and clears whenever WAIT is left.
    always_comb begin
        stateNext      = state;
        cntNext        = '0;
        bufNext        = bufData;
        timeoutErrNext = timeoutErr;
        matchFire      = 1'b0;
        case (state)
            IDLE: begin
                if (rdAccept) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (rspHit && !rdAccept) begin
                    stateNext = READY;
                    bufNext   = rspData;
                end else if (timeoutHit) begin
                    stateNext      = READY;
                    bufNext        = TIMEOUT_DATA;
                    timeoutErrNext = 1'b1;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            READY: begin
                if (threadSel) begin
                    stateNext = IDLE;
                    matchFire = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // FSM state register.
    `LOTR_RST_MSFF(state, stateNext, QClk, RstQnnnH, IDLE)

    // Watchdog counter.
    `LOTR_RST_MSFF(cnt, cntNext, QClk, RstQnnnH, '0)

    // Returned-data buffer.
    `LOTR_RST_MSFF(bufData, bufNext, QClk, RstQnnnH, '0)

    // Sticky timeout flag.
    `LOTR_RST_MSFF(timeoutErr, timeoutErrNext, QClk, RstQnnnH, 1'b0)

endmodule

// File: rtl/c2f_req_tracker.sv
// Core-to-fabric request tracker: forwards off-core reads/writes to the ring
// through a one-entry stall hold register, and tracks one outstanding read per
// hardware thread until its data is handed back to the pipeline.

`ifndef LOTR_RST_MSFF
`define LOTR_RST_MSFF(q, d, clk, rst, rstVal) \
    always_ff @(posedge clk) begin \
        if (rst) q <= rstVal; \
        else     q <= d; \
    end
`endif

module c2f_req_tracker
    import lotr_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int TID_W       = $clog2(NUM_THREADS),
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   QClk,
    input  logic                   RstQnnnH,
    input  logic [NUM_THREADS-1:0] ThreadQ103H,
    input  logic                   RemoteRdQ103H,
    input  logic                   RemoteWrQ103H,
    input  logic [31:0]            AddressQ103H,
    input  logic [31:0]            WrDataQ103H,
    input  logic                   C2F_ReqStall,
    output logic                   C2F_ReqValidQ500H,
    output t_opcode                C2F_ReqOpcodeQ500H,
    output logic [TID_W-1:0]       C2F_ReqThreadIDQ500H,
    output logic [31:0]            C2F_ReqAddressQ500H,
    output logic [31:0]            C2F_ReqDataQ500H,
    output logic                   ReqReady,
    input  logic                   C2F_RspValidQ502H,
    input  logic [TID_W-1:0]       C2F_RspThreadIDQ502H,
    input  logic [31:0]            C2F_RspDataQ502H,
    output logic [NUM_THREADS-1:0] RcAccess,
    output logic                   C2F_RspMatchQ104H,
    output logic [31:0]            C2F_RspDataQ504H,
    output logic [NUM_THREADS-1:0] TimeoutErr,
    output logic                   OverflowErr
);

    logic [7:0]             threadPad;
    logic [TID_W-1:0]       curTid;
    t_opcode                curOp;
    logic                   reqNew;
    logic                   reqAccept;

    logic                   holdValid;
    logic                   holdValidNext;
    t_opcode                holdOp;
    t_opcode                holdOpNext;
    logic [TID_W-1:0]       holdTid;
    logic [TID_W-1:0]       holdTidNext;
    logic [31:0]            holdAddr;
    logic [31:0]            holdAddrNext;
    logic [31:0]            holdData;
    logic [31:0]            holdDataNext;
    logic                   overflowNext;

    logic [NUM_THREADS-1:0] rdAcceptVec;
    logic [NUM_THREADS-1:0] rspHitVec;
    logic [NUM_THREADS-1:0] matchFire;
    logic [31:0]            slotBuf [NUM_THREADS];
    logic                   matchAny;
    logic [31:0]            matchData;
    logic [31:0]            rspDataNext;

    assign threadPad = 8'(ThreadQ103H);
    assign curTid    = TID_W'(encodeOneHot8(threadPad));
    assign curOp     = RemoteWrQ103H ? WR : RD;
    assign reqNew    = RemoteRdQ103H | RemoteWrQ103H;
    assign ReqReady  = ~holdValid;
    assign reqAccept = C2F_ReqValidQ500H & ~C2F_ReqStall;

    // Ring request mux: a held request always takes priority over the live pipeline request.
    always_comb begin
        C2F_ReqValidQ500H    = reqNew;
        C2F_ReqOpcodeQ500H   = curOp;
        C2F_ReqThreadIDQ500H = curTid;
        C2F_ReqAddressQ500H  = AddressQ103H;
        C2F_ReqDataQ500H     = WrDataQ103H;
        if (holdValid) begin
            C2F_ReqValidQ500H    = 1'b1;
            C2F_ReqOpcodeQ500H   = holdOp;
            C2F_ReqThreadIDQ500H = holdTid;
            C2F_ReqAddressQ500H  = holdAddr;
            C2F_ReqDataQ500H     = holdData;
        end
    end

    // Hold register update: capture a stalled live request, drop (and flag) anything arriving while full.
    always_comb begin
        holdValidNext = holdValid;
        holdOpNext    = holdOp;
        holdTidNext   = holdTid;
        holdAddrNext  = holdAddr;
        holdDataNext  = holdData;
        overflowNext  = OverflowErr;
        if (holdValid) begin
            if (!C2F_ReqStall) begin
                holdValidNext = 1'b0;
            end
            if (reqNew) begin
                overflowNext = 1'b1;
            end
        end else if (reqNew && C2F_ReqStall) begin
            holdValidNext = 1'b1;
            holdOpNext    = curOp;
            holdTidNext   = curTid;
            holdAddrNext  = AddressQ103H;
            holdDataNext  = WrDataQ103H;
        end
    end

    // Hold register valid bit.
    `LOTR_RST_MSFF(holdValid, holdValidNext, QClk, RstQnnnH, 1'b0)

    // Hold register opcode.
    `LOTR_RST_MSFF(holdOp, holdOpNext, QClk, RstQnnnH, RD)

    // Hold register thread ID.
    `LOTR_RST_MSFF(holdTid, holdTidNext, QClk, RstQnnnH, '0)

    // Hold register address.
    `LOTR_RST_MSFF(holdAddr, holdAddrNext, QClk, RstQnnnH, '0)

    // Hold register write data.
    `LOTR_RST_MSFF(holdData, holdDataNext, QClk, RstQnnnH, '0)

    // Sticky dropped-request flag.
    `LOTR_RST_MSFF(OverflowErr, overflowNext, QClk, RstQnnnH, 1'b0)

    for (genvar t = 0; t < NUM_THREADS; t++) begin : gSlot
        assign rdAcceptVec[t] = reqAccept && (C2F_ReqOpcodeQ500H == RD)
                                && (C2F_ReqThreadIDQ500H == TID_W'(t));
        assign rspHitVec[t]   = C2F_RspValidQ502H && (C2F_RspThreadIDQ502H == TID_W'(t));

        c2f_thread_slot #(
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) uSlot (
            .QClk       (QClk),
            .RstQnnnH   (RstQnnnH),
            .rdAccept   (rdAcceptVec[t]),
            .rspHit     (rspHitVec[t]),
            .rspData    (C2F_RspDataQ502H),
            .threadSel  (ThreadQ103H[t]),
            .rcAccess   (RcAccess[t]),
            .matchFire  (matchFire[t]),
            .bufData    (slotBuf[t]),
            .timeoutErr (TimeoutErr[t])
        );
    end

    // Select the buffer of the slot handing data back this cycle (at most one, threads are one-hot).
    always_comb begin
        matchAny  = |matchFire;
        matchData = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (matchFire[t]) begin
                matchData = matchData | slotBuf[t];
            end
        end
        rspDataNext = matchAny ? matchData : C2F_RspDataQ504H;
    end

    // Q104H match pulse.
    `LOTR_RST_MSFF(C2F_RspMatchQ104H, matchAny, QClk, RstQnnnH, 1'b0)

    // Q504H returned data, held between matches.
    `LOTR_RST_MSFF(C2F_RspDataQ504H, rspDataNext, QClk, RstQnnnH, '0)

endmodule

// File: tb/tb_c2f_req_tracker.sv
// Directed bench for c2f_req_tracker: a 4-thread build with a short timeout
// and an 8-thread build for the highest thread ID.
module tb_c2f_req_tracker;
    import lotr_pkg::*;

    logic        qClk = 1'b0;
    logic        rst;
    logic        rdReq;
    logic        wrReq;
    logic [3:0]  thread4;
    logic [7:0]  thread8;
    logic [31:0] addr;
    logic [31:0] wrData;
    logic        stall;
    logic        rspValid;
    logic [1:0]  rspTid4;
    logic [2:0]  rspTid8;
    logic [31:0] rspData;

    logic        reqValid4;
    t_opcode     reqOp4;
    logic [1:0]  reqTid4;
    logic [31:0] reqAddr4;
    logic [31:0] reqData4;
    logic        reqReady4;
    logic [3:0]  rcAccess4;
    logic        match4;
    logic [31:0] matchData4;
    logic [3:0]  timeoutErr4;
    logic        overflow4;

    logic        reqValid8;
    t_opcode     reqOp8;
    logic [2:0]  reqTid8;
    logic [31:0] reqAddr8;
    logic [31:0] reqData8;
    logic        reqReady8;
    logic [7:0]  rcAccess8;
    logic        match8;
    logic [31:0] matchData8;
    logic [7:0]  timeoutErr8;
    logic        overflow8;

    int checkCount = 0;
    int failCount  = 0;

    // Free-running 10 ns clock.
    always #5 qClk = ~qClk;

    c2f_req_tracker #(
        .NUM_THREADS (4),
        .TIMEOUT_CYC (16)
    ) dut4 (
        .QClk                 (qClk),
        .RstQnnnH             (rst),
        .ThreadQ103H          (thread4),
        .RemoteRdQ103H        (rdReq),
        .RemoteWrQ103H        (wrReq),
        .AddressQ103H         (addr),
        .WrDataQ103H          (wrData),
        .C2F_ReqStall         (stall),
        .C2F_ReqValidQ500H    (reqValid4),
        .C2F_ReqOpcodeQ500H   (reqOp4),
        .C2F_ReqThreadIDQ500H (reqTid4),
        .C2F_ReqAddressQ500H  (reqAddr4),
        .C2F_ReqDataQ500H     (reqData4),
        .ReqReady             (reqReady4),
        .C2F_RspValidQ502H    (rspValid),
        .C2F_RspThreadIDQ502H (rspTid4),
        .C2F_RspDataQ502H     (rspData),
        .RcAccess             (rcAccess4),
        .C2F_RspMatchQ104H    (match4),
        .C2F_RspDataQ504H     (matchData4),
        .TimeoutErr           (timeoutErr4),
        .OverflowErr          (overflow4)
    );

    c2f_req_tracker #(
        .NUM_THREADS (8),
        .TIMEOUT_CYC (1024)
    ) dut8 (
        .QClk                 (qClk),
        .RstQnnnH             (rst),
        .ThreadQ103H          (thread8),
        .RemoteRdQ103H        (rdReq),
        .RemoteWrQ103H        (wrReq),
        .AddressQ103H         (addr),
        .WrDataQ103H          (wrData),
        .C2F_ReqStall         (stall),
        .C2F_ReqValidQ500H    (reqValid8),
        .C2F_ReqOpcodeQ500H   (reqOp8),
        .C2F_ReqThreadIDQ500H (reqTid8),
        .C2F_ReqAddressQ500H  (reqAddr8),
        .C2F_ReqDataQ500H     (reqData8),
        .ReqReady             (reqReady8),
        .C2F_RspValidQ502H    (rspValid),
        .C2F_RspThreadIDQ502H (rspTid8),
        .C2F_RspDataQ502H     (rspData),
        .RcAccess             (rcAccess8),
        .C2F_RspMatchQ104H    (match8),
        .C2F_RspDataQ504H     (matchData8),
        .TimeoutErr           (timeoutErr8),
        .OverflowErr          (overflow8)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge qClk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [3:0] thr,
                                 input logic [31:0] a, input logic [31:0] d, input logic st);
        rdReq   = rd;
        wrReq   = wr;
        thread4 = thr;
        addr    = a;
        wrData  = d;
        stall   = st;
        #1;
    endtask

    task automatic applyResponse(input logic v, input logic [1:0] tid4, input logic [2:0] tid8,
                                 input logic [31:0] d);
        rspValid = v;
        rspTid4  = tid4;
        rspTid8  = tid8;
        rspData  = d;
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        thread8 = '0;
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
        applyResponse(1'b0, 2'd0, 3'd0, 32'h0);
        doReset();

        $display("[TB] reset state");
        checkOutput("rstReqReady", reqReady4, 1);
        checkOutput("rstReqValid", reqValid4, 0);
        checkOutput("rstRcAccess", rcAccess4, 0);
        checkOutput("rstMatch", match4, 0);
        checkOutput("rstMatchData", matchData4, 0);
        checkOutput("rstTimeout", timeoutErr4, 0);
        checkOutput("rstOverflow", overflow4, 0);

        $display("[TB] T1 read round trip");
        applyStimulus(1'b1, 1'b0, 4'b0010, 32'h0200_0010, 32'h0, 1'b0);
        checkOutput("t1ReqValid", reqValid4, 1);
        checkOutput("t1ReqTid", reqTid4, 1);
        checkOutput("t1ReqOp", 32'(reqOp4), 0);
        checkOutput("t1ReqAddr", reqAddr4, 32'h0200_0010);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
        checkOutput("t1RcWait", rcAccess4, 4'b0010);
        applyResponse(1'b1, 2'd1, 3'd1, 32'h1234_5678);
        tick();
        applyResponse(1'b0, 2'd0, 3'd0, 32'h0);
        checkOutput("t1RcReady", rcAccess4, 4'b0010);
        checkOutput("t1NoEarlyMatch", match4, 0);
        applyStimulus(1'b0, 1'b0, 4'b0010, 32'h0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
        checkOutput("t1Match", match4, 1);
        checkOutput("t1MatchData", matchData4, 32'h1234_5678);
        checkOutput("t1RcDone", rcAccess4, 0);
        tick();
        checkOutput("t1MatchPulse", match4, 0);

        $display("[TB] stalled write and overflow");
        applyStimulus(1'b0, 1'b1, 4'b0001, 32'h0000_0100, 32'h0000_AAAA, 1'b1);
        checkOutput("stReady0", reqReady4, 1);
        checkOutput("stValid0", reqValid4, 1);
        tick();
        applyStimulus(1'b1, 1'b0, 4'b0100, 32'h0000_0300, 32'h0, 1'b1);
        checkOutput("stReady1", reqReady4, 0);
        checkOutput("stAddr1", reqAddr4, 32'h0000_0100);
        checkOutput("stData1", reqData4, 32'h0000_AAAA);
        checkOutput("stOp1", 32'(reqOp4), 1);
        checkOutput("stTid1", reqTid4, 0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
        checkOutput("stOverflow", overflow4, 1);
        checkOutput("stReady2", reqReady4, 0);
        checkOutput("stAddr2", reqAddr4, 32'h0000_0100);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
        checkOutput("stReady3", reqReady4, 0);
        checkOutput("stValid3", reqValid4, 1);
        checkOutput("stAddr3", reqAddr4, 32'h0000_0100);
        tick();
        checkOutput("stReady4", reqReady4, 1);
        checkOutput("stValid4", reqValid4, 0);
        checkOutput("stDroppedRd", rcAccess4, 0);
        checkOutput("stOverflowSticky", overflow4, 1);
        doReset();
        checkOutput("stOverflowClr", overflow4, 0);

        $display("[TB] T0 and T3 outstanding, responses out of order");
        applyStimulus(1'b1, 1'b0, 4'b0001, 32'h0000_0010, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 4'b1000, 32'h0000_0030, 32'h0, 1'b0);
        applyResponse(1'b1, 2'd3, 3'd3, 32'hFFFF_FFFF);
        checkOutput("ooTid3", reqTid4, 3);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
        applyResponse(1'b1, 2'd1, 3'd1, 32'h0000_0BAD);
        checkOutput("ooRcBoth", rcAccess4, 4'b1001);
        tick();
        checkOutput("ooIgnoreIdle", rcAccess4, 4'b1001);
        applyResponse(1'b1, 2'd3, 3'd3, 32'h3333_3333);
        tick();
        applyResponse(1'b1, 2'd0, 3'd0, 32'h0000_0A0A);
        tick();
        applyResponse(1'b0, 2'd0, 3'd0, 32'h0);
        applyStimulus(1'b0, 1'b0, 4'b1000, 32'h0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0001, 32'h0, 32'h0, 1'b0);
        checkOutput("ooMatch3", match4, 1);
        checkOutput("ooData3", matchData4, 32'h3333_3333);
        checkOutput("ooRcAfter3", rcAccess4, 4'b0001);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
        checkOutput("ooMatch0", match4, 1);
        checkOutput("ooData0", matchData4, 32'h0000_0A0A);
        checkOutput("ooRcAfter0", rcAccess4, 0);
        tick();
        checkOutput("ooMatchPulse", match4, 0);

        $display("[TB] T2 timeout");
        applyStimulus(1'b1, 1'b0, 4'b0100, 32'h0000_0020, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        checkOutput("toBefore", timeoutErr4, 0);
        tick();
        checkOutput("toFlag", timeoutErr4, 4'b0100);
        checkOutput("toRcReady", rcAccess4, 4'b0100);
        applyStimulus(1'b0, 1'b0, 4'b0100, 32'h0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
        checkOutput("toMatch", match4, 1);
        checkOutput("toData", matchData4, 32'hDEAD_BEEF);
        checkOutput("toRcDone", rcAccess4, 0);

        $display("[TB] reset while waiting");
        applyStimulus(1'b1, 1'b0, 4'b0010, 32'h0000_0040, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
        checkOutput("rwWait", rcAccess4, 4'b0010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyResponse(1'b1, 2'd1, 3'd1, 32'h0000_0055);
        tick();
        applyResponse(1'b0, 2'd0, 3'd0, 32'h0);
        checkOutput("rwRcClr", rcAccess4, 0);
        checkOutput("rwTimeoutClr", timeoutErr4, 0);
        applyStimulus(1'b0, 1'b0, 4'b0010, 32'h0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
        checkOutput("rwNoMatch1", match4, 0);
        tick();
        checkOutput("rwNoMatch2", match4, 0);

        $display("[TB] 8-thread build, T7 round trip");
        doReset();
        thread8 = 8'h80;
        applyStimulus(1'b1, 1'b0, 4'b0000, 32'h0700_0070, 32'h0, 1'b0);
        checkOutput("t7ReqValid", reqValid8, 1);
        checkOutput("t7ReqTid", reqTid8, 7);
        tick();
        thread8 = 8'h00;
        applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
        checkOutput("t7RcWait", rcAccess8, 8'h80);
        applyResponse(1'b1, 2'd0, 3'd7, 32'h7777_0007);
        tick();
        applyResponse(1'b0, 2'd0, 3'd0, 32'h0);
        thread8 = 8'h80;
        #1;
        tick();
        thread8 = 8'h00;
        #1;
        checkOutput("t7Match", match8, 1);
        checkOutput("t7Data", matchData8, 32'h7777_0007);
        checkOutput("t7RcDone", rcAccess8, 0);

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
